mul_issue_unit: RTL and testbench

- Front/back-end stage for the sequential Booth `multiplier` in the RV32M execute path. Accepts MUL/MULH/MULHSU/MULHU requests over a valid/ready handshake and latches the operands.
- Pulses the multiplier's start/reset, waits for its `done`, then applies unsigned high-word correction and selects the low or high word.
- Returns the 32-bit result over a second valid/ready handshake to the writeback logic.

---
 rtl/mul_issue_unit.sv | 190 +++++++++++++++++++
 tb/tb_mul_issue_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_unit.sv
// RV32M multiply issue stage: wraps a sequential radix-2 Booth multiplier and applies the MULH/MULHSU/MULHU fix-ups.
// Optional macro MUL_ZERO_BYPASS_EN: zero operands skip the multiplier and respond one cycle after accept.

module multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p,
  output logic        done
);

  logic [32:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] a_q;
  logic        q1_q;
  logic [5:0]  cnt_q;
  logic [32:0] a_ext;
  logic [32:0] sum;

  // A 33-bit accumulator absorbs the overflow of subtracting -2^31
  always_comb begin
    a_ext = {a_q[31], a_q};
    case ({lo_q[0], q1_q})
      2'b01:   sum = hi_q + a_ext;
      2'b10:   sum = hi_q - a_ext;
      default: sum = hi_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= b;
      a_q   <= a;
      q1_q  <= 1'b0;
      cnt_q <= '0;
    end else if (!done) begin
      hi_q  <= {sum[32], sum[32:1]};
      lo_q  <= {sum[0], lo_q[31:1]};
      q1_q  <= lo_q[0];
      cnt_q <= cnt_q + 6'd1;
    end
  end

  assign done = (cnt_q == 6'd32);
  assign p    = {hi_q[31:0], lo_q};

endmodule

module mul_issue_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, FIX, RESP} state_e;

  state_e      state_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [2:0]  f3_q;
  logic [31:0] result_q;
  logic [31:0] result_d;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;
  logic        mult_rst;
  logic        mult_done;
  logic [63:0] prod;

  // Holding the multiplier in reset while idle guarantees a fresh done per operation
  assign mult_rst = (state_q == LOAD) | ~rst_n | (state_q == IDLE);

  multiplier u_mult (
    .clk  (clk),
    .rst  (mult_rst),
    .a    (rs1_q),
    .b    (rs2_q),
    .p    (prod),
    .done (mult_done)
  );

  // Signed-by-signed high word is turned into the SU/UU high word by adding back the operands
  always_comb begin
    case (f3_q)
      3'b001:  result_d = prod[63:32];
      3'b010:  result_d = prod[63:32] + (rs2_q[31] ? rs1_q : 32'd0);
      3'b011:  result_d = prod[63:32] + (rs1_q[31] ? rs2_q : 32'd0)
                                      + (rs2_q[31] ? rs1_q : 32'd0);
      default: result_d = prod[31:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      f3_q        <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && !flush) begin
            rs1_q      <= in_rs1;
            rs2_q      <= in_rs2;
            f3_q       <= in_funct3;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
            if (in_rs1 == '0 || in_rs2 == '0) begin
              state_q     <= RESP;
              result_q    <= '0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= LOAD;
            end
`else
            state_q <= LOAD;
`endif
          end
        end
        LOAD: begin
          if (flush) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else if (mult_done) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            state_q     <= RESP;
            result_q    <= result_d;
            out_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (flush || out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mul_issue_unit.sv
// Directed self-checking bench for mul_issue_unit: functions, backpressure, flush, reset and response/request overlap.
// Zero-operand latency expectation follows MUL_ZERO_BYPASS_EN.

module tb_mul_issue_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  int vecs = 0;
  int miss = 0;

  mul_issue_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct3  (in_funct3),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; the DUT is expected to be idle.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    in_funct3 = f3;
    in_rs1    = a;
    in_rs2    = b;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic waitValid(input string tag, output int lat);
    lat = 1;
    while (!out_valid && lat < 300) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int lat;
    out_ready = 1'b1;
    applyStimulus(f3, a, b);
    waitValid(tag, lat);
    checkOutput({tag, "_result"}, out_result, exp);
    tick();
    checkOutput({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_funct3 = 3'b000;
    in_rs1    = '0;
    in_rs2    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_result",    out_result,         32'd0);
    checkOutput("rst_busy",      {31'd0, busy},      32'd0);
    rst_n = 1'b1;
    tick();

    runOp("mul_7xm3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) pulses++;
      tick();
    end
    checkOutput("mul_single_pulse", pulses, 32'd0);

    runOp("mulh_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
    runOp("mulhu_ones", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    runOp("mulhsu_ones",3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    runOp("mulhsu_pos", 3'b010, 32'h00000003, 32'hFFFFFFFF, 32'h00000002);
    runOp("mulhu_mix",  3'b011, 32'h80000000, 32'h00000004, 32'h00000002);
    runOp("rsvd_f3",    3'b100, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);

    // Backpressure: result must be held while out_ready is low
    out_ready = 1'b0;
    applyStimulus(3'b011, 32'h00010000, 32'h00010000);
    checkOutput("bp_in_ready_busy", {31'd0, in_ready}, 32'd0);
    waitValid("bp", lat);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_hold_valid",  {31'd0, out_valid}, 32'd1);
      checkOutput("bp_hold_result", out_result,         32'h00000001);
      checkOutput("bp_hold_ready",  {31'd0, in_ready},  32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    checkOutput("bp_accept_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_accept_ready", {31'd0, in_ready},  32'd1);

    // Flush during WAIT kills the operation
    applyStimulus(3'b000, 32'd3, 32'd5);
    tick();
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_busy",     {31'd0, busy},     32'd0);
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) pulses++;
      tick();
    end
    checkOutput("flush_no_valid", pulses, 32'd0);
    runOp("after_flush", 3'b000, 32'd3, 32'd5, 32'h0000000F);

    // Flush in IDLE blocks a same-cycle request
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_funct3 = 3'b000;
    in_rs1    = 32'd9;
    in_rs2    = 32'd9;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("idle_flush_busy", {31'd0, busy}, 32'd0);

    // Flush in RESP discards the result
    out_ready = 1'b0;
    applyStimulus(3'b000, 32'd4, 32'd4);
    waitValid("resp_flush", lat);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("resp_flush_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("resp_flush_busy",  {31'd0, busy},      32'd0);
    out_ready = 1'b1;

    // Reset pulse during WAIT
    applyStimulus(3'b000, 32'd11, 32'd13);
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midrst_valid",    {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready},  32'd1);
    checkOutput("midrst_busy",     {31'd0, busy},      32'd0);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) pulses++;
      tick();
    end
    checkOutput("midrst_no_valid", pulses, 32'd0);
    runOp("after_rst", 3'b000, 32'd2, 32'd2, 32'h00000004);

    // Result accepted while a new request waits: one bubble before acceptance
    out_ready = 1'b0;
    applyStimulus(3'b000, 32'd5, 32'd5);
    waitValid("overlap_first", lat);
    checkOutput("overlap_first_result", out_result, 32'd25);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_funct3 = 3'b000;
    in_rs1    = 32'd6;
    in_rs2    = 32'd7;
    tick();
    checkOutput("overlap_drop",   {31'd0, out_valid}, 32'd0);
    checkOutput("overlap_bubble", {31'd0, busy},      32'd0);
    tick();
    in_valid = 1'b0;
    checkOutput("overlap_taken",  {31'd0, busy},      32'd1);
    waitValid("overlap_second", lat);
    checkOutput("overlap_second_result", out_result, 32'd42);
    tick();

    // Zero operand: bypass responds one cycle after accept, else full path
    applyStimulus(3'b001, 32'd0, 32'h12345678);
    waitValid("zero", lat);
    checkOutput("zero_result", out_result, 32'd0);
`ifdef MUL_ZERO_BYPASS_EN
    checkOutput("zero_latency", lat, 32'd1);
`else
    checkOutput("zero_latency_long", {31'd0, (lat > 3)}, 32'd1);
`endif
    tick();
    checkOutput("zero_drop", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
